serial: RTL and testbench

//  Parallel-to-serial transmitter: accepts one DATA_W-bit word on a valid_in strobe and shifts it out LSB-first, one bit per clock.

---
 rtl/serial_if.sv | 24 ++
 rtl/serial.sv | 104 ++++++++++
 tb/tb_serial.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_if.sv
// Bundle of the serial transmitter's signals; clk and rst enter as interface ports.
// The dut modport fixes signal direction as seen by the transmitter.
interface serial_if #(
  parameter int DATA_W = 4
) (
  input logic clk,
  input logic rst
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              busy_out;
  logic              serial_out;
  logic              valid_out;

  modport dut (
    input  clk,
    input  rst,
    input  valid_in,
    input  data_in,
    output busy_out,
    output serial_out,
    output valid_out
  );
endinterface

// File: rtl/serial.sv
// LSB-first parallel-to-serial transmitter; SERIAL_PARITY_EN appends an even-parity bit.
// valid_out pulses DATA_W(+1) edges after acceptance; requests are ignored unless IDLE.
module serial #(
  parameter int DATA_W = 4
) (
  serial_if.dut bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              busy_q, busy_nxt;
  logic              valid_q, valid_nxt;
  logic              ser_q, ser_nxt;
`ifdef SERIAL_PARITY_EN
  logic              par, par_nxt;
`endif

  // Outputs are computed for the next state and flopped, so nothing from the inputs reaches them combinationally.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    busy_nxt  = 1'b0;
    valid_nxt = 1'b0;
    ser_nxt   = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          state_nxt = SHIFT;
          sreg_nxt  = bus.data_in;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          ser_nxt   = bus.data_in[0];
`ifdef SERIAL_PARITY_EN
          par_nxt   = ^bus.data_in;
`endif
        end
      end
      SHIFT: begin
        sreg_nxt = sreg >> 1;
        if (cnt == CW'(DATA_W - 1)) begin
          cnt_nxt = '0;
`ifdef SERIAL_PARITY_EN
          state_nxt = PAR;
          busy_nxt  = 1'b1;
          ser_nxt   = par;
`else
          state_nxt = DONE;
          valid_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt  = cnt + 1'b1;
          busy_nxt = 1'b1;
          ser_nxt  = sreg[1];
        end
      end
      PAR: begin
        state_nxt = DONE;
        valid_nxt = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ser_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      ser_q   <= ser_nxt;
`ifdef SERIAL_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  assign bus.busy_out   = busy_q;
  assign bus.valid_out  = valid_q;
  assign bus.serial_out = ser_q;
endmodule

// File: tb/tb_serial.sv
// Directed bench for serial: outputs sampled 1ns after each rising edge as {busy, valid, serial}.
// Frame length follows SERIAL_PARITY_EN so the same bench covers both builds.
module tb_serial;
`ifdef SERIAL_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_if #(.DATA_W(4)) sif (.clk(clk), .rst(rst));
  serial #(.DATA_W(4)) dut (.bus(sif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [3:0] d, input int k);
    if (k < 4) return d[k];
    return ^d;
  endfunction

  function automatic logic [2:0] obs();
    return {sif.busy_out, sif.valid_out, sif.serial_out};
  endfunction

  task automatic test_reset;
    logic [2:0] o;
    rst = 1'b1;
    sif.valid_in = 1'b0;
    sif.data_in  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      tick();
      o = obs();
      n_checks++;
      if (o !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_cycle%0d: got %b want 000", c, o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] d;
    logic [2:0] o;
    logic [2:0] e;
    d = 4'h5;
    sif.valid_in = 1'b1;
    sif.data_in  = d;
    tick();
    sif.valid_in = 1'b0;
    sif.data_in  = 4'h0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) tick();
      o = obs();
      e = {1'b1, 1'b0, exp_bit(d, k)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_bit%0d: got %b want %b", k, o, e);
      end
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b010) begin
      n_fail++;
      $display("FAIL single_done: got %b want 010", o);
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b000) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 000", o);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] words [3];
    logic [3:0] d;
    logic [2:0] o;
    logic [2:0] e;
    int         pulses;
    words[0] = 4'hA;
    words[1] = 4'h6;
    words[2] = 4'h9;
    pulses = 0;
    sif.valid_in = 1'b1;
    sif.data_in  = words[0];
    for (int w = 0; w < 3; w++) begin
      d = words[w];
      tick();
      sif.valid_in = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (k > 0) tick();
        o = obs();
        e = {1'b1, 1'b0, exp_bit(d, k)};
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b_w%0d_bit%0d: got %b want %b", w, k, o, e);
        end
      end
      tick();
      o = obs();
      if (o[1] === 1'b1) pulses++;
      n_checks++;
      if (o !== 3'b010) begin
        n_fail++;
        $display("FAIL b2b_w%0d_done: got %b want 010", w, o);
      end
      // Next request raised as soon as valid_out is seen; the DONE edge must ignore it.
      if (w < 2) begin
        sif.valid_in = 1'b1;
        sif.data_in  = words[w+1];
      end
      tick();
      o = obs();
      n_checks++;
      if (o !== 3'b000) begin
        n_fail++;
        $display("FAIL b2b_w%0d_idle: got %b want 000", w, o);
      end
    end
    n_checks++;
    if (pulses !== 3) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_hold_toggle;
    logic [3:0] d;
    logic [3:0] d2;
    logic [2:0] o;
    logic [2:0] e;
    d  = 4'h5;
    d2 = 4'h3;
    sif.valid_in = 1'b1;
    sif.data_in  = d;
    tick();
    for (int k = 0; k < NB; k++) begin
      if (k > 0) tick();
      o = obs();
      e = {1'b1, 1'b0, exp_bit(d, k)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hold_bit%0d: got %b want %b", k, o, e);
      end
      sif.data_in = ~sif.data_in;
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b010) begin
      n_fail++;
      $display("FAIL hold_done: got %b want 010", o);
    end
    sif.data_in = d2;
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b000) begin
      n_fail++;
      $display("FAIL hold_gap: got %b want 000", o);
    end
    tick();
    sif.valid_in = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) tick();
      o = obs();
      e = {1'b1, 1'b0, exp_bit(d2, k)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hold_next_bit%0d: got %b want %b", k, o, e);
      end
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b010) begin
      n_fail++;
      $display("FAIL hold_next_done: got %b want 010", o);
    end
    tick();
  endtask

  task automatic test_reset_midframe;
    logic [2:0] o;
    sif.valid_in = 1'b1;
    sif.data_in  = 4'hF;
    tick();
    sif.valid_in = 1'b0;
    tick();
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b101) begin
      n_fail++;
      $display("FAIL midrst_bit2: got %b want 101", o);
    end
    rst = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_async: got %b want 000", o);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NB + 2; c++) begin
      tick();
      o = obs();
      n_checks++;
      if (o !== 3'b000) begin
        n_fail++;
        $display("FAIL midrst_after%0d: got %b want 000", c, o);
      end
    end
  endtask

  task automatic test_parity;
    logic [3:0] d;
    logic [2:0] o;
    logic [2:0] e;
    d = 4'h7;
    sif.valid_in = 1'b1;
    sif.data_in  = d;
    tick();
    sif.valid_in = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) tick();
      o = obs();
      e = {1'b1, 1'b0, exp_bit(d, k)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL parity_bit%0d: got %b want %b", k, o, e);
      end
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b010) begin
      n_fail++;
      $display("FAIL parity_done: got %b want 010", o);
    end
    tick();
    o = obs();
    n_checks++;
    if (o !== 3'b000) begin
      n_fail++;
      $display("FAIL parity_idle: got %b want 000", o);
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.valid_in = 1'b0;
    sif.data_in  = 4'h0;
    test_reset();
    tick();
    test_single();
    test_back_to_back();
    test_hold_toggle();
    test_reset_midframe();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
